wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the dual-clock FIFO; the source end of the pointer handoff whose destination is the `sync` two-flop synchronizer. It advances a binary write address on every accepted write and publishes a registered Gray-coded write pointer for synchronization into the read domain. It compares the next pointer against the already-synchronized read pointer to drive full, almost-full and fill level. It lives entirely in the write clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/wptr_full.sv | 63 ++++++
 tb/tb_wptr_full.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default address width and
// Gray-code conversion helpers used by both pointer blocks.
package fifo_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; callers zero-extend narrower pointers.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned i = 31; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full.sv
// Write-domain pointer for the dual-clock FIFO: binary address, registered
// Gray pointer for the read-side synchronizer, and full/almost-full/level flags.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W   = fifo_pkg::ADDR_W_DEFAULT,
    parameter int unsigned AFULL_TH = (2 ** ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              wafull,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam int unsigned     PW        = ADDR_W + 1;
    localparam logic [ADDR_W:0] AFULL_LVL = AFULL_TH[ADDR_W:0];

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rbin_s;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] full_cmp;

    // Blocked while rst is high so nothing reaches memory during reset.
    assign wen   = winc & ~wfull & ~rst;
    assign waddr = wbin[ADDR_W-1:0];

    always_comb begin
        wbin_next  = wbin + {{ADDR_W{1'b0}}, wen};
        wgray_next = PW'(bin2gray(32'(wbin_next)));
        rbin_s     = PW'(gray2bin(32'(wq2_rptr)));
        level_next = wbin_next - rbin_s;
        // Full when the two MSBs differ and the rest match in Gray space.
        full_cmp   = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wfull  <= (wgray_next == full_cmp);
            wafull <= (level_next >= AFULL_LVL);
            wlevel <= level_next;
            wovf   <= wovf | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full at ADDR_W=2, AFULL_TH=3.
module tb_wptr_full;

    typedef struct {
        logic [2:0] ptr;
        logic [2:0] lvl;
        logic [1:0] addr;
        logic       full;
        logic       afull;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [2:0] rq;
    logic       wen;
    logic [1:0] waddr;
    logic [2:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [2:0] wlevel;
    logic       wovf;

    int unsigned total  = 0;
    int unsigned passed = 0;

    exp_t       sb[$];
    logic [2:0] m_bin;
    logic       m_full;
    logic       m_ovf;

    wptr_full #(.ADDR_W(2), .AFULL_TH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .winc     (winc),
        .wq2_rptr (rq),
        .wen      (wen),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] b2g(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_bin  = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle from a falling edge, push the predicted post-edge state,
    // then pop and compare after the rising edge.
    task automatic step(input logic w, input logic [2:0] r);
        exp_t       e;
        exp_t       got;
        logic [2:0] nb;
        logic       acc;
        winc = w;
        rq   = r;
        #1;
        acc = w & ~m_full;
        chk("wen", 32'(wen), 32'(acc));
        chk("waddr_pre", 32'(waddr), 32'(m_bin[1:0]));
        nb      = m_bin + {2'b00, acc};
        e.lvl   = nb - g2b(r);
        e.full  = (e.lvl == 3'd4);
        e.afull = (e.lvl >= 3'd3);
        e.ptr   = b2g(nb);
        e.addr  = nb[1:0];
        e.ovf   = m_ovf | (w & m_full);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("wptr", 32'(wptr), 32'(got.ptr));
        chk("wlevel", 32'(wlevel), 32'(got.lvl));
        chk("wfull", 32'(wfull), 32'(got.full));
        chk("wafull", 32'(wafull), 32'(got.afull));
        chk("wovf", 32'(wovf), 32'(got.ovf));
        chk("waddr", 32'(waddr), 32'(got.addr));
        m_bin  = nb;
        m_full = got.full;
        m_ovf  = got.ovf;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"}, 32'(wen), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wptr"}, 32'(wptr), 0);
        chk({tag, "_wfull"}, 32'(wfull), 0);
        chk({tag, "_wafull"}, 32'(wafull), 0);
        chk({tag, "_wlevel"}, 32'(wlevel), 0);
        chk({tag, "_wovf"}, 32'(wovf), 0);
    endtask

    initial begin
        logic [2:0] ptr_tab [4];
        logic [2:0] prev;
        logic [2:0] rd;
        logic       wrapped;
        int unsigned guard;
        ptr_tab[0] = 3'b001;
        ptr_tab[1] = 3'b011;
        ptr_tab[2] = 3'b010;
        ptr_tab[3] = 3'b110;

        // Reset held with a write request pending.
        rst  = 1'b1;
        winc = 1'b1;
        rq   = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        @(negedge clk);
        rst = 1'b0;

        // Four writes from empty; first one is the first edge after release.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b000);
            chk("seq_wptr", 32'(wptr), 32'(ptr_tab[i]));
            chk("seq_wlevel", 32'(wlevel), 32'(i + 1));
            chk("seq_wafull", 32'(wafull), (i >= 2) ? 1 : 0);
            chk("seq_wfull", 32'(wfull), (i == 3) ? 1 : 0);
            if (i == 0) chk("first_waddr", 32'(waddr), 1);
        end

        // Write attempt while full.
        step(1'b1, 3'b000);
        chk("ovf_wptr_hold", 32'(wptr), 32'(3'b110));
        chk("ovf_set", 32'(wovf), 1);
        step(1'b0, 3'b000);
        chk("ovf_sticky", 32'(wovf), 1);

        // One read becomes visible, then refill.
        step(1'b0, 3'b001);
        chk("rd_wfull", 32'(wfull), 0);
        chk("rd_wlevel", 32'(wlevel), 3);
        step(1'b1, 3'b001);
        chk("refill_wptr", 32'(wptr), 32'(3'b111));
        chk("refill_wfull", 32'(wfull), 1);

        // Clean reset before the wrap-around run.
        #2 rst = 1'b1;
        #1 chk_all_zero("pulse_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Twelve writes with the read pointer trailing by one entry.
        wrapped = 1'b0;
        for (int i = 0; i < 12; i++) begin
            prev = wptr;
            rd   = (m_bin == 3'd0) ? 3'd0 : m_bin - 3'd1;
            step(1'b1, b2g(rd));
            chk("wrap_1bit", 32'($countones(prev ^ wptr)), 1);
            chk("wrap_nofull", 32'(wfull), 0);
            chk("wrap_noovf", 32'(wovf), 0);
            if (prev == 3'b100 && wptr == 3'b000) wrapped = 1'b1;
        end
        chk("wrap_seen", 32'(wrapped), 1);

        // Advance to wptr=010, then reset asynchronously between edges.
        guard = 0;
        while (wptr != 3'b010 && guard < 16) begin
            rd = m_bin - 3'd1;
            step(1'b1, b2g(rd));
            guard++;
        end
        chk("reach_010", 32'(wptr), 32'(3'b010));
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        model_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
